// File: rtl/nest_checker_pkg.sv
// Shared definitions for the nest_checker block: word-FSM state encoding,
// ASCII constants, separator test and case folding.
// Optional feature macro: SEP_WS_EN (tab, LF and CR also act as separators).
package nest_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_OTHER = 4'd1,
    ST_B1    = 4'd2,
    ST_B2    = 4'd3,
    ST_B3    = 4'd4,
    ST_B4    = 4'd5,
    ST_BGN   = 4'd6,
    ST_E1    = 4'd7,
    ST_E2    = 4'd8,
    ST_END   = 4'd9
  } word_state_t;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  localparam logic [7:0] CH_B = 8'h62;
  localparam logic [7:0] CH_E = 8'h65;
  localparam logic [7:0] CH_G = 8'h67;
  localparam logic [7:0] CH_I = 8'h69;
  localparam logic [7:0] CH_N = 8'h6E;
  localparam logic [7:0] CH_D = 8'h64;

  // True when the character ends a word.
  function automatic logic is_sep(input logic [7:0] c);
`ifdef SEP_WS_EN
    return (c == CH_SPACE) || (c == CH_TAB) || (c == CH_LF) || (c == CH_CR);
`else
    return (c == CH_SPACE);
`endif
  endfunction

  // Fold upper-case ASCII letters to lower case; everything else unchanged.
  function automatic logic [7:0] lower(input logic [7:0] c);
    if ((c >= 8'h41) && (c <= 8'h5A)) return c | 8'h20;
    return c;
  endfunction

endpackage

// File: rtl/nest_word_fsm.sv
// Word tokeniser: tracks how far the current word matches "begin" or "end"
// and flags a keyword that is pending or being committed by a separator.
module nest_word_fsm
  import nest_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       step,
  input  logic [7:0] ch,
  output logic       kw_begin_pend,
  output logic       kw_end_pend,
  output logic       commit_begin,
  output logic       commit_end
);

  word_state_t state;
  word_state_t nxt;
  logic [7:0]  lc;
  logic        sep;

  // Next state for the character presented this cycle.
  always_comb begin
    lc  = lower(ch);
    sep = is_sep(ch);
    nxt = ST_OTHER;
    if (sep) begin
      nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (lc == CH_B)      nxt = ST_B1;
          else if (lc == CH_E) nxt = ST_E1;
        end
        ST_B1: if (lc == CH_E) nxt = ST_B2;
        ST_B2: if (lc == CH_G) nxt = ST_B3;
        ST_B3: if (lc == CH_I) nxt = ST_B4;
        ST_B4: if (lc == CH_N) nxt = ST_BGN;
        ST_E1: if (lc == CH_N) nxt = ST_E2;
        ST_E2: if (lc == CH_D) nxt = ST_END;
        default: nxt = ST_OTHER;
      endcase
    end
  end

  // State register; holds across idle cycles, clear returns to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     state <= ST_IDLE;
    else if (clr)  state <= ST_IDLE;
    else if (step) state <= nxt;
  end

  // Keyword flags for the depth logic in the top level.
  always_comb begin
    kw_begin_pend = (state == ST_BGN);
    kw_end_pend   = (state == ST_END);
    commit_begin  = step && sep && (state == ST_BGN);
    commit_end    = step && sep && (state == ST_END);
  end

endmodule

// File: rtl/nest_checker.sv
// Streaming begin/end nesting checker. Owns the committed depth, the sticky
// error flags and the balanced/depth outputs; word matching lives in
// nest_word_fsm. Optional feature macro: SEP_WS_EN (see nest_pkg).
// Handshake: a character is consumed on every rising edge where in_valid is
// high and clr is low; there is no backpressure. Once an error is flagged all
// input is ignored until reset or clr.
module nest_checker
  import nest_pkg::*;
#(
  parameter int DEPTH_W   = 8,
  parameter int MAX_DEPTH = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in,
  input  logic               clr,
  output logic               result,
  output logic [DEPTH_W-1:0] depth,
  output logic               err_under,
  output logic               err_over
);

  localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);

  logic [DEPTH_W-1:0] cdepth;
  logic               lock;
  logic               step;
  logic               kw_begin_pend;
  logic               kw_end_pend;
  logic               commit_begin;
  logic               commit_end;
  logic               at_max;
  logic               at_zero;

  // Input qualification: clear wins, and an error freezes everything.
  always_comb begin
    lock    = err_under || err_over;
    step    = in_valid && !clr && !lock;
    at_max  = (cdepth == MAX_D);
    at_zero = (cdepth == '0);
  end

  nest_word_fsm u_word (
    .clk           (clk),
    .reset         (reset),
    .clr           (clr),
    .step          (step),
    .ch            (in),
    .kw_begin_pend (kw_begin_pend),
    .kw_end_pend   (kw_end_pend),
    .commit_begin  (commit_begin),
    .commit_end    (commit_end)
  );

  // Committed depth and sticky errors, updated when a keyword is terminated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cdepth    <= '0;
      err_under <= 1'b0;
      err_over  <= 1'b0;
    end else if (clr) begin
      cdepth    <= '0;
      err_under <= 1'b0;
      err_over  <= 1'b0;
    end else if (commit_begin) begin
      if (!at_max) cdepth   <= cdepth + 1'b1;
      else         err_over <= 1'b1;
    end else if (commit_end) begin
      if (!at_zero) cdepth    <= cdepth - 1'b1;
      else          err_under <= 1'b1;
    end
  end

  // Effective depth (with pending keyword) and the balanced indication.
  always_comb begin
    depth = cdepth;
    if (kw_begin_pend && !at_max)     depth = cdepth + 1'b1;
    else if (kw_end_pend && !at_zero) depth = cdepth - 1'b1;
    result = (depth == '0) && !lock
             && !(kw_end_pend && at_zero)
             && !(kw_begin_pend && at_max);
  end

endmodule

// File: tb/tb_nest_checker.sv
// Bench for nest_checker: two instances (default depth, and MAX_DEPTH=2) share
// the input stream and are compared each cycle against a word-level model.
module tb_nest_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in = 8'h00;
  logic       clr = 1'b0;

  logic       result_a, err_under_a, err_over_a;
  logic [7:0] depth_a;
  logic       result_b, err_under_b, err_over_b;
  logic [1:0] depth_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Clock
  always #5 clk = ~clk;

  nest_checker #(.DEPTH_W(8), .MAX_DEPTH(255)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in), .clr(clr),
    .result(result_a), .depth(depth_a), .err_under(err_under_a), .err_over(err_over_a)
  );

  nest_checker #(.DEPTH_W(2), .MAX_DEPTH(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in), .clr(clr),
    .result(result_b), .depth(depth_b), .err_under(err_under_b), .err_over(err_over_b)
  );

  // Reference model: current word text (lower-cased, first 6 chars kept),
  // committed depth and sticky errors, one set per instance.
  int         m_max[2] = '{255, 2};
  int         m_cd[2];
  bit         m_eu[2];
  bit         m_eo[2];
  int         m_len[2];
  logic [7:0] m_w[2][6];

  function automatic bit tb_sep(input logic [7:0] c);
`ifdef SEP_WS_EN
    return c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D;
`else
    return c == 8'h20;
`endif
  endfunction

  function automatic logic [7:0] tb_lower(input logic [7:0] c);
    if (c >= "A" && c <= "Z") return c + 8'd32;
    return c;
  endfunction

  function automatic bit word_is_begin(input int i);
    return m_len[i] == 5 && m_w[i][0] == "b" && m_w[i][1] == "e" &&
           m_w[i][2] == "g" && m_w[i][3] == "i" && m_w[i][4] == "n";
  endfunction

  function automatic bit word_is_end(input int i);
    return m_len[i] == 3 && m_w[i][0] == "e" && m_w[i][1] == "n" && m_w[i][2] == "d";
  endfunction

  function automatic int exp_depth(input int i);
    if (word_is_begin(i) && m_cd[i] < m_max[i]) return m_cd[i] + 1;
    if (word_is_end(i) && m_cd[i] > 0) return m_cd[i] - 1;
    return m_cd[i];
  endfunction

  function automatic bit exp_result(input int i);
    return exp_depth(i) == 0 && !m_eu[i] && !m_eo[i] &&
           !(word_is_end(i) && m_cd[i] == 0) &&
           !(word_is_begin(i) && m_cd[i] == m_max[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cd[i] = 0; m_eu[i] = 0; m_eo[i] = 0; m_len[i] = 0;
    end
  endtask

  task automatic model_char(input logic [7:0] c);
    for (int i = 0; i < 2; i++) begin
      if (!(m_eu[i] || m_eo[i])) begin
        if (tb_sep(c)) begin
          if (word_is_begin(i)) begin
            if (m_cd[i] < m_max[i]) m_cd[i]++; else m_eo[i] = 1;
          end else if (word_is_end(i)) begin
            if (m_cd[i] > 0) m_cd[i]--; else m_eu[i] = 1;
          end
          m_len[i] = 0;
        end else if (m_len[i] < 6) begin
          m_w[i][m_len[i]] = tb_lower(c);
          m_len[i]++;
        end
      end
    end
  endtask

  // Driver + scoreboard: apply one cycle, advance the model, compare both DUTs.
  task automatic drive(input string tag, input logic [7:0] c, input logic v, input logic cl);
    logic [7:0] d_got[2];
    logic       r_got[2], u_got[2], o_got[2];
    @(negedge clk);
    in = c; in_valid = v; clr = cl;
    @(posedge clk);
    #1;
    if (cl) model_reset();
    else if (v) model_char(c);
    d_got = '{depth_a, {6'b0, depth_b}};
    r_got = '{result_a, result_b};
    u_got = '{err_under_a, err_under_b};
    o_got = '{err_over_a, err_over_b};
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (d_got[i] !== 8'(exp_depth(i))) begin
        n_fail++;
        $display("FAIL %s[%0d] depth after 0x%02h: got %0d want %0d", tag, i, c, d_got[i], exp_depth(i));
      end
      n_tests++;
      if (r_got[i] !== exp_result(i)) begin
        n_fail++;
        $display("FAIL %s[%0d] result after 0x%02h: got %0b want %0b", tag, i, c, r_got[i], exp_result(i));
      end
      n_tests++;
      if (u_got[i] !== m_eu[i]) begin
        n_fail++;
        $display("FAIL %s[%0d] err_under after 0x%02h: got %0b want %0b", tag, i, c, u_got[i], m_eu[i]);
      end
      n_tests++;
      if (o_got[i] !== m_eo[i]) begin
        n_fail++;
        $display("FAIL %s[%0d] err_over after 0x%02h: got %0b want %0b", tag, i, c, o_got[i], m_eo[i]);
      end
    end
  endtask

  task automatic send_str(input string tag, input string s);
    for (int j = 0; j < s.len(); j++) drive(tag, s[j], 1'b1, 1'b0);
  endtask

  task automatic do_clr(input string tag);
    drive(tag, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1);
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic async_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 in_valid = 1'b0; clr = 1'b0;
    model_reset();
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    async_reset();
    #1;
    n_tests++;
    if (depth_a !== 8'd0 || result_a !== 1'b1 || err_under_a !== 1'b0 || err_over_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_a: got depth=%0d result=%0b eu=%0b eo=%0b want 0 1 0 0",
               depth_a, result_a, err_under_a, err_over_a);
    end
    n_tests++;
    if (depth_b !== 2'd0 || result_b !== 1'b1 || err_under_b !== 1'b0 || err_over_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_b: got depth=%0d result=%0b eu=%0b eo=%0b want 0 1 0 0",
               depth_b, result_b, err_under_b, err_over_b);
    end
  endtask

  task automatic test_begin_end();
    async_reset();
    send_str("begin_end", "begin");
    n_tests++;
    if (depth_a !== 8'd1 || result_a !== 1'b0) begin
      n_fail++;
      $display("FAIL begin_pending: got depth=%0d result=%0b want 1 0", depth_a, result_a);
    end
    send_str("begin_end", " end ");
    n_tests++;
    if (depth_a !== 8'd0 || result_a !== 1'b1) begin
      n_fail++;
      $display("FAIL begin_end_final: got depth=%0d result=%0b want 0 1", depth_a, result_a);
    end
  endtask

  task automatic test_case_insens();
    async_reset();
    send_str("case", "BeGiN beginx ");
    n_tests++;
    if (depth_a !== 8'd1 || result_a !== 1'b0) begin
      n_fail++;
      $display("FAIL case_beginx: got depth=%0d result=%0b want 1 0", depth_a, result_a);
    end
  endtask

  task automatic test_underflow();
    async_reset();
    send_str("under", "end");
    send_str("under", "x ");
    async_reset();
    send_str("under", "end ");
    n_tests++;
    if (err_under_a !== 1'b1 || result_a !== 1'b0) begin
      n_fail++;
      $display("FAIL under_flag: got eu=%0b result=%0b want 1 0", err_under_a, result_a);
    end
    send_str("under_lock", "begin ");
    do_clr("under_clr");
  endtask

  task automatic test_overflow();
    async_reset();
    send_str("over", "begin begin begin ");
    n_tests++;
    if (err_over_b !== 1'b1 || depth_b !== 2'd2 || result_b !== 1'b0) begin
      n_fail++;
      $display("FAIL over_b: got eo=%0b depth=%0d result=%0b want 1 2 0", err_over_b, depth_b, result_b);
    end
    send_str("over_lock", "end end x ");
    do_clr("over_clr");
  endtask

  task automatic test_whitespace();
    async_reset();
    send_str("ws", "begin\tend\n");
    send_str("ws", " ");
  endtask

  task automatic test_gaps();
    async_reset();
    send_str("gaps", "beg");
    for (int k = 0; k < 5; k++) drive("gaps_idle", 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    send_str("gaps", "in ");
    n_tests++;
    if (depth_a !== 8'd1) begin
      n_fail++;
      $display("FAIL gaps_depth: got %0d want 1", depth_a);
    end
    async_reset();
    send_str("gaps_rst", "beg");
    async_reset();
    send_str("gaps_rst", "in ");
    n_tests++;
    if (depth_a !== 8'd0) begin
      n_fail++;
      $display("FAIL midword_reset_depth: got %0d want 0", depth_a);
    end
  endtask

  task automatic test_random();
    string words[10] = '{"begin", "end", "BEGIN", "EnD", "beg", "endx", "x", "begins", "b", "en"};
    logic [7:0] seps[4] = '{8'h20, 8'h09, 8'h0A, 8'h0D};
    string w;
    async_reset();
    for (int it = 0; it < 400; it++) begin
      w = words[$urandom_range(0, 9)];
      for (int j = 0; j < w.len(); j++) begin
        if ($urandom_range(0, 5) == 0)
          drive("rand_gap", 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        drive("rand", w[j], 1'b1, 1'b0);
      end
      drive("rand_sep", seps[$urandom_range(0, 3)], 1'b1, 1'b0);
      if ($urandom_range(0, 30) == 0) do_clr("rand_clr");
      if ($urandom_range(0, 60) == 0) async_reset();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_begin_end();
    test_case_insens();
    test_underflow();
    test_overflow();
    test_whitespace();
    test_gaps();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nest_checker.md
# nest_checker

Streaming keyword-nesting checker: consumes one ASCII character per valid cycle, tokenises on separators, and tracks `begin`/`end` nesting depth with a parametrised counter, overflow and underflow detection, and a synchronous soft clear. It sits on the character-input path of the text-processing datapath and reports in real time whether the text seen so far is balanced.

## Interface
Parameters:
- DEPTH_W, 8, width of the nesting-depth counter
- MAX_DEPTH, 255, largest legal depth; must be ≤ 2^DEPTH_W − 1

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  `in` is consumed on this rising edge
- in  input  8  ASCII character
- clr  input  1  synchronous clear; has priority over in_valid
- result  output  1  text so far is balanced and error-free
- depth  output  DEPTH_W  effective nesting depth, including a pending keyword
- err_under  output  1  sticky: an `end` was committed at depth 0
- err_over  output  1  sticky: a `begin` was committed at depth MAX_DEPTH

## Operation
- Keyword matching is case-insensitive. A word is a maximal run of non-separator characters. The separator is 0x20; see Configuration.
- Word FSM states:
  - IDLE: between words.
  - OTHER: inside a non-keyword word.
  - B1..B4: prefixes `b`, `be`, `beg`, `begi`.
  - BGN: full `begin`.
  - E1, E2: prefixes `e`, `en`.
  - END: full `end`.
- Transitions:
  - Any separator returns the FSM to IDLE.
  - A matching next letter advances the FSM.
  - Any other non-separator character goes to OTHER. This includes a sixth letter after BGN and a fourth letter after END.
- Committed depth `cdepth` is updated only when a separator arrives in BGN or END:
  - From BGN: if cdepth < MAX_DEPTH, cdepth+1; otherwise set err_over and leave cdepth unchanged.
  - From END: if cdepth > 0, cdepth−1; otherwise set err_under.
- Pending adjustment: `depth` = cdepth + 1 in BGN when cdepth < MAX_DEPTH; cdepth − 1 in END when cdepth > 0; otherwise cdepth. A pending keyword reverts when the word grows.
- result = 1 only when all of the following hold:
  - depth == 0
  - no sticky error
  - the FSM is not in END with cdepth == 0 (pending underflow)
  - the FSM is not in BGN with cdepth == MAX_DEPTH (pending overflow)
- Error lock: once either error is set, all input is ignored and outputs hold until reset or clr.
- The word FSM state persists across in_valid gaps.

## Timing
- Reset values: FSM = IDLE, cdepth = 0, depth = 0, err_under = 0, err_over = 0, result = 1.
- Outputs are combinational from registers only (no input-to-output paths). An input consumed at edge N is reflected in the outputs after edge N.
- clr = 1 at an edge returns all state to reset values, regardless of in_valid.
- An asynchronous reset mid-word discards the partial word.
- Simultaneous commit and new word: the separator cycle commits, and the next character starts a fresh match from IDLE.

## Configuration
- SEP_WS_EN defined: separators are 0x20, 0x09 (tab), 0x0A (LF) and 0x0D (CR).
- SEP_WS_EN undefined: the only separator is 0x20; tab, LF and CR are ordinary word characters.

## Structure
- Package `nest_pkg`:
  - FSM state enum (IDLE, OTHER, B1–B4, BGN, E1, E2, END).
  - ASCII constants for the separators and the keyword letters.
  - Function `is_sep(byte)` wrapping the SEP_WS_EN choice.
  - Function `lower(byte)` for case folding.
- Sub-module `nest_word_fsm` holds the word FSM and exposes `kw_begin_pend`, `kw_end_pend`, `commit_begin` and `commit_end`. The top level owns cdepth, the error flags and the output logic.

## Test plan
- "begin end " with DEPTH_W=8: depth 1 after `n`, 0 after the final `d`, stays 0 after the space; result = 1 at end; result = 0 after the first `n` until `end` is pending.
- "BeGiN beginx " → depth 1 after `BeGiN`; depth returns to 1 (not 2) after `x`; result = 0.
- "end" → result = 0 after `d`; then "x" → result = 1, depth = 0. Separately, "end " → err_under = 1, result = 0; subsequent "begin " ignored; clr → result = 1, errors = 0.
- MAX_DEPTH=2: "begin begin begin " → depth 2, err_over = 1 after the third space; further input ignored.
- With SEP_WS_EN: "begin\tend\n" → result = 1, depth = 0. Without it, the same stream is one word: depth 0, result = 1, no commit.
- in_valid toggling: "beg", then in_valid low 5 cycles, then "in " → depth 1; an asynchronous reset between `g` and `i` → IDLE and depth 0, so "in " is an ordinary word (depth 0).
